// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared definitions for the run controller of the 4-bit JK counter.
//   CNT_W   : default counter width, must match the downstream counter
//   state_t : controller state encoding (IDLE/CLEAR/RUN/DONE)
package counter_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/counter_ctrl_chk.sv
// counter_ctrl_chk
// Shadow-count checker. It tracks how many toggles the controller has issued
// since entering RUN and flags a sticky error when the fed-back count
// disagrees with that number while in RUN.
// Only instantiated when COUNTER_CTRL_CHECK_EN is defined.
// Ports:
//   clk        : clock shared with the controller and counter
//   rst_n      : synchronous active-low reset
//   start_acc  : a start request was accepted this cycle (clears err)
//   run_enter  : the controller enters RUN at the next edge (zeroes shadow)
//   in_run     : the controller is currently in RUN
//   jk_en      : toggle enable being sent to the counter
//   cnt_q      : counter value fed back
//   err        : sticky mismatch flag
module counter_ctrl_chk #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_acc,
    input  logic             run_enter,
    input  logic             in_run,
    input  logic             jk_en,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             err
);

    logic [CNT_W-1:0] shadow;

    // The shadow zeroes as RUN begins (the counter is at 0 then, and jk_en is
    // low on that cycle), and afterwards follows every issued toggle. A
    // mismatch seen in RUN latches err until reset or the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            err    <= 1'b0;
        end else begin
            if (run_enter) begin
                shadow <= '0;
            end else if (jk_en) begin
                shadow <= shadow + CNT_W'(1);
            end

            if (start_acc) begin
                err <= 1'b0;
            end else if (in_run && (cnt_q != shadow)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Run controller for a JK-flip-flop counter that has no reset of its own.
// On an accepted start it toggles the counter until it wraps to zero, then
// toggles it up to the latched target and freezes it there.
// Optional feature macro: COUNTER_CTRL_CHECK_EN (shadow-count error checker).
// Ports:
//   clk    : single clock, shared with the counter
//   rst_n  : synchronous active-low reset
//   start  : run request, only honoured in IDLE
//   target : terminal count, latched when start is accepted
//   cnt_q  : counter output fed back
//   jk_en  : shared J/K toggle enable for the counter's bit-0 stage
//   busy   : high in every state except IDLE
//   done   : one-cycle pulse once the counter holds the target
//   err    : sticky mismatch flag (tied low without the checker)
module counter_ctrl #(
    parameter int CNT_W = counter_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             jk_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import counter_ctrl_pkg::*;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] tgt_r;
    logic             start_acc;

    assign start_acc = (state == IDLE) && start;

    // State register and target latch. Target is captured only on acceptance
    // so later changes on the target input cannot disturb a run in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt_r <= '0;
        end else begin
            state <= state_nx;
            if (start_acc) begin
                tgt_r <= target;
            end
        end
    end

    // Next state and toggle decode. CLEAR toggles until the counter wraps to
    // zero; RUN toggles until it equals the target. jk_en stays low in IDLE and
    // DONE so the counter is frozen between runs.
    always_comb begin
        state_nx = state;
        jk_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                jk_en = (cnt_q != '0);
                if (cnt_q == '0) begin
                    state_nx = (tgt_r == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                jk_en = (cnt_q != tgt_r);
                if (cnt_q == tgt_r) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef COUNTER_CTRL_CHECK_EN
    logic run_enter;
    logic in_run;

    assign run_enter = (state != RUN) && (state_nx == RUN);
    assign in_run    = (state == RUN);

    counter_ctrl_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_acc (start_acc),
        .run_enter (run_enter),
        .in_run    (in_run),
        .jk_en     (jk_en),
        .cnt_q     (cnt_q),
        .err       (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
// Bench for counter_ctrl. It emulates the downstream 4-bit counter (with a
// preset hook and an optional one-shot skip), keeps a timeline model of what
// every run must look like cycle by cycle, and compares jk_en/busy/done/err
// against that timeline on every falling edge. Directed runs add literal
// expectations for toggle counts, done latency and final count.
module tb_counter_ctrl;

    localparam int W = 4;
`ifdef COUNTER_CTRL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] target;
    logic [W-1:0] cnt;
    logic         jk_en;
    logic         busy;
    logic         done;
    logic         err;

    logic         preset_en;
    logic [W-1:0] preset_val;
    logic         skip_arm;
    logic         skip_used;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic jk;
        logic busy;
        logic done;
        logic err_set;
    } step_t;

    step_t sched[$];
    logic  exp_err;
    bit    model_ready = 1'b0;

    counter_ctrl #(
        .CNT_W (W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .cnt_q  (cnt),
        .jk_en  (jk_en),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Downstream counter: increments when toggled, can be preset by the
    // bench, and can be made to jump by two once to provoke a mismatch.
    always @(posedge clk) begin
        if (preset_en) begin
            cnt <= preset_val;
        end else if (jk_en === 1'b1) begin
            if (skip_arm && !skip_used) begin
                cnt       <= cnt + 4'd2;
                skip_used <= 1'b1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
        if (!skip_arm) begin
            skip_used <= 1'b0;
        end
    end

    task automatic check_output(input string nm, input logic [31:0] act,
                                input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Expected timeline of one run: clear toggles until wrap, one idle CLEAR
    // cycle at zero, then count toggles, one settle cycle, and the DONE pulse.
    task automatic build_run(input logic [W-1:0] c, input logic [W-1:0] t,
                             input bit skip);
        int n_clr;
        int n_run;
        int base;
        n_clr = (c == 0) ? 0 : (2 ** W) - int'(c);
        for (int i = 0; i < n_clr; i++) sched.push_back(step_t'(4'b1100));
        sched.push_back(step_t'(4'b0100));
        base = sched.size();
        if (t != 0) begin
            n_run = skip ? int'(t) - 1 : int'(t);
            for (int i = 0; i < n_run; i++) sched.push_back(step_t'(4'b1100));
            sched.push_back(step_t'(4'b0100));
        end
        sched.push_back(step_t'(4'b0110));
        if (skip && (base + 2 < sched.size())) begin
            sched[base + 2].err_set = 1'b1;
        end
    endtask

    // Model advance on every rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            sched.delete();
            exp_err     = 1'b0;
            model_ready = 1'b1;
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
            if (sched.size() > 0 && sched[0].err_set && CHK) exp_err = 1'b1;
        end else if (start) begin
            build_run(cnt, target, skip_arm);
            exp_err = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        step_t e;
        if (model_ready) begin
            e = (sched.size() > 0) ? sched[0] : step_t'(4'b0000);
            check_output("jk_en", 32'(jk_en), 32'(e.jk));
            check_output("busy",  32'(busy),  32'(e.busy));
            check_output("done",  32'(done),  32'(e.done));
            check_output("err",   32'(err),   32'(exp_err));
        end
    end

    task automatic apply_stimulus(input logic [W-1:0] val);
        @(posedge clk);
        #2 preset_en = 1'b1;
        preset_val = val;
        @(posedge clk);
        #2 preset_en = 1'b0;
    endtask

    task automatic run_case(input string nm, input logic [W-1:0] t,
                            input bit skip, input bit guard, input bit use_lit,
                            input int exp_jk, input int exp_k);
        int  jk;
        int  k;
        bit  seen;
        jk = 0;
        k = -1;
        seen = 1'b0;
        @(posedge clk);
        #2 start = 1'b1;
        target = t;
        skip_arm = skip;
        @(posedge clk);
        #2 start = 1'b0;
        target = ~t;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                k = i;
            end else if (jk_en) begin
                jk++;
            end
            if (guard && i == 3) begin
                start = 1'b1;
                target = 4'd2;
            end
            if (guard && i == 4) start = 1'b0;
        end
        check_output({nm, " done seen"}, 32'(seen), 32'd1);
        check_output({nm, " final count"}, 32'(cnt), 32'(t));
        if (use_lit) begin
            check_output({nm, " toggles"}, 32'(jk), 32'(exp_jk));
            check_output({nm, " done edge"}, 32'(k), 32'(exp_k));
        end
        skip_arm = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        target     = '0;
        preset_en  = 1'b1;
        preset_val = '0;
        skip_arm   = 1'b0;
        skip_used  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset jk_en", 32'(jk_en), 32'd0);
        check_output("reset busy",  32'(busy),  32'd0);
        check_output("reset done",  32'(done),  32'd0);
        check_output("reset err",   32'(err),   32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        preset_en = 1'b0;

        run_case("t5 clean",  4'd5, 1'b0, 1'b0, 1'b1, 5, 7);
        apply_stimulus(4'd12);
        run_case("t3 dirty12", 4'd3, 1'b0, 1'b0, 1'b1, 7, 9);
        apply_stimulus(4'd0);
        run_case("t0 clean",  4'd0, 1'b0, 1'b0, 1'b1, 0, 1);
        apply_stimulus(4'd9);
        run_case("t0 dirty9", 4'd0, 1'b0, 1'b0, 1'b1, 7, 8);
        apply_stimulus(4'd0);
        run_case("t6 skip",   4'd6, 1'b1, 1'b0, 1'b1, 5, 7);
        check_output("skip err sticky", 32'(err), 32'(CHK));
        run_case("b2b t2",    4'd2, 1'b0, 1'b0, 1'b1, 12, 14);
        run_case("b2b t4",    4'd4, 1'b0, 1'b0, 1'b1, 18, 20);
        apply_stimulus(4'd0);
        run_case("busy guard", 4'd10, 1'b0, 1'b1, 1'b1, 10, 12);

        apply_stimulus(4'd0);
        @(posedge clk);
        #2 start = 1'b1;
        target = 4'd8;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("midrun reset jk_en", 32'(jk_en), 32'd0);
        check_output("midrun reset busy",  32'(busy),  32'd0);
        #2 rst_n = 1'b1;

        run_case("after reset t1", 4'd1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
